// File: rtl/kbd_event_ctrl_pkg.sv
// Shared definitions for the keyboard event controller.
//  - PS/2 set-2 scancode constants for prefixes, modifiers and caps lock
//  - event word bit positions and packed event struct
//  - decoder state enum
//  - helper that recognises keyboard protocol filler bytes
package kbd_event_ctrl_pkg;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_E1      = 8'hE1;
    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_ALT     = 8'h11;
    localparam logic [7:0] SC_CAPS    = 8'h58;

    // Bytes that follow E1 in the Pause make sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int unsigned EVT_W     = 16;
    localparam int unsigned EVT_BRK   = 15;
    localparam int unsigned EVT_EXT   = 14;
    localparam int unsigned EVT_SHIFT = 13;
    localparam int unsigned EVT_CTRL  = 12;
    localparam int unsigned EVT_CAPS  = 11;
    localparam int unsigned EVT_ALT   = 10;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } dec_state_e;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic       shift;
        logic       ctrl;
        logic       caps;
        logic       alt;
        logic [1:0] rsvd;
        logic [7:0] code;
    } kbd_evt_t;

    // Self-test results, echo, ack, resend, error and overrun bytes carry no key.
    function automatic logic is_filler(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// CPU-side event bus of the keyboard event controller.
//  evt_rd     consumer pops head event
//  err_clr    consumer clears sticky error
//  evt_valid  event FIFO non-empty
//  evt_data   head event (show-ahead)
//  evt_count  entries held
//  err        sticky error flag
// master: CPU/MMIO consumer, slave: kbd_event_ctrl.
interface kbd_event_ctrl_if #(
    parameter int unsigned DEPTH = 8
);
    import kbd_event_ctrl_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             evt_rd;
    logic             err_clr;
    logic             evt_valid;
    logic [EVT_W-1:0] evt_data;
    logic [CW-1:0]    evt_count;
    logic             err;

    modport master (
        output evt_rd,
        output err_clr,
        input  evt_valid,
        input  evt_data,
        input  evt_count,
        input  err
    );

    modport slave (
        input  evt_rd,
        input  err_clr,
        output evt_valid,
        output evt_data,
        output evt_count,
        output err
    );

endinterface

// File: rtl/kbd_event_ctrl_fifo.sv
// Circular show-ahead event FIFO.
//  clk, clrn  clock, synchronous active-low reset
//  push/wdata write request and data
//  pop        read request (ignored when empty)
//  rdata      head entry, zero when empty
//  valid      non-empty
//  count      entries held
//  drop       pulse: push lost because FIFO full and not popping
module kbd_event_ctrl_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             full, empty, do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign valid = ~empty;
    assign count = cnt_q;
    assign rdata = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata;
        end
    end

    // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by natural overflow.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Keyboard event controller: drains the ps2_keyboard scancode FIFO, folds
// E0/F0/E1 prefix sequences into key events, tracks modifier/caps-lock state
// and queues 16-bit make/break events for a CPU-side consumer.
//  clk, clrn      clock, synchronous active-low reset
//  kb_data        scancode from ps2_keyboard
//  kb_ready       ps2_keyboard holds a byte
//  kb_overflow    ps2_keyboard FIFO overflow
//  kb_nextdata_n  active-low pop strobe to ps2_keyboard
//  bus            event bus (evt_rd, evt_valid, evt_data, evt_count, err, err_clr)
//  caps_led       caps-lock state
module kbd_event_ctrl
    import kbd_event_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter bit          SUPPRESS = 1'b1
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [7:0]             kb_data,
    input  logic                   kb_ready,
    input  logic                   kb_overflow,
    output logic                   kb_nextdata_n,
    kbd_event_ctrl_if.slave        bus,
    output logic                   caps_led
);

    logic       nextdata_n_q;
    dec_state_e state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       shl_q, shl_d, shr_q, shr_d;
    logic       ctrl_q, ctrl_d, alt_q, alt_d;
    logic       caps_q, caps_d;
    logic [8:0] held_q, held_d;
    logic       err_q, err_d;

    logic       accept;
    logic       from_idle;
    logic       key_hit, key_brk, key_ext;
    logic [8:0] key;
    logic       repeat_hit;
    logic       push, fifo_drop;
    kbd_evt_t   evt;
    logic [$clog2(DEPTH):0] fifo_count;

    // A byte is taken only while the strobe is idle high, which forces the
    // strobe low for exactly one cycle and then high for at least one.
    assign accept = kb_ready & nextdata_n_q;

    // E0/E1 seen after E0 restart decoding as if from idle.
    assign from_idle = (state_q == StIdle) ||
                       ((state_q == StExt) && ((kb_data == SC_E0) || (kb_data == SC_E1)));

    // Decoder next state.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        key_hit = 1'b0;
        key_brk = 1'b0;
        key_ext = 1'b0;
        if (kb_overflow) begin
            state_d = StIdle;
        end else if (accept) begin
            if (from_idle) begin
                state_d = StIdle;
                if (kb_data == SC_E0) begin
                    state_d = StExt;
                end else if (kb_data == SC_F0) begin
                    state_d = StBrk;
                end else if (kb_data == SC_E1) begin
                    state_d = StSkip;
                    skip_d  = PAUSE_SKIP;
                end else if (!is_filler(kb_data)) begin
                    key_hit = 1'b1;
                end
            end else begin
                unique case (state_q)
                    StExt: begin
                        if (kb_data == SC_F0) begin
                            state_d = StExtBrk;
                        end else begin
                            key_hit = 1'b1;
                            key_ext = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    StBrk: begin
                        key_hit = 1'b1;
                        key_brk = 1'b1;
                        state_d = StIdle;
                    end
                    StExtBrk: begin
                        key_hit = 1'b1;
                        key_brk = 1'b1;
                        key_ext = 1'b1;
                        state_d = StIdle;
                    end
                    StSkip: begin
                        skip_d = skip_q - 3'd1;
                        if (skip_q == 3'd1) state_d = StIdle;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    assign key        = {key_ext, kb_data};
    assign repeat_hit = SUPPRESS && key_hit && !key_brk && (key == held_q);

    // Modifier, caps and held-key tracking; event reflects state after update.
    always_comb begin
        shl_d  = shl_q;
        shr_d  = shr_q;
        ctrl_d = ctrl_q;
        alt_d  = alt_q;
        caps_d = caps_q;
        held_d = held_q;
        if (key_hit) begin
            if (kb_data == SC_SHIFT_L) shl_d  = ~key_brk;
            if (kb_data == SC_SHIFT_R) shr_d  = ~key_brk;
            if (kb_data == SC_CTRL)    ctrl_d = ~key_brk;
            if (kb_data == SC_ALT)     alt_d  = ~key_brk;
            if (!key_brk && !repeat_hit && (kb_data == SC_CAPS)) caps_d = ~caps_q;
            if (!key_brk) begin
                held_d = key;
            end else if (key == held_q) begin
                held_d = '0;
            end
        end
    end

    assign push = key_hit & ~repeat_hit;

    always_comb begin
        evt       = '0;
        evt.brk   = key_brk;
        evt.ext   = key_ext;
        evt.shift = shl_d | shr_d;
        evt.ctrl  = ctrl_d;
        evt.caps  = caps_d;
        evt.alt   = alt_d;
        evt.code  = kb_data;
    end

    // Sticky error: a new set wins over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (kb_overflow || fifo_drop) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            nextdata_n_q <= 1'b1;
            state_q      <= StIdle;
            skip_q       <= '0;
            shl_q        <= 1'b0;
            shr_q        <= 1'b0;
            ctrl_q       <= 1'b0;
            alt_q        <= 1'b0;
            caps_q       <= 1'b0;
            held_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            nextdata_n_q <= ~accept;
            state_q      <= state_d;
            skip_q       <= skip_d;
            shl_q        <= shl_d;
            shr_q        <= shr_d;
            ctrl_q       <= ctrl_d;
            alt_q        <= alt_d;
            caps_q       <= caps_d;
            held_q       <= held_d;
            err_q        <= err_d;
        end
    end

    kbd_event_ctrl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .wdata (evt),
        .pop   (bus.evt_rd),
        .rdata (bus.evt_data),
        .valid (bus.evt_valid),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    assign bus.evt_count = fifo_count;
    assign bus.err       = err_q;
    assign kb_nextdata_n = nextdata_n_q;
    assign caps_led      = caps_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
module tb_kbd_event_ctrl;
    localparam int unsigned DEPTH    = 8;
    localparam bit          SUPPRESS = 1'b1;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       kb_nextdata_n;
    logic       caps_led;

    kbd_event_ctrl_if #(.DEPTH(DEPTH)) bus ();

    kbd_event_ctrl #(
        .DEPTH    (DEPTH),
        .SUPPRESS (SUPPRESS)
    ) dut (
        .clk           (clk),
        .clrn          (clrn),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (kb_nextdata_n),
        .bus           (bus),
        .caps_led      (caps_led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model at key-event level.
    logic [15:0] exp_q[$];
    logic        m_err, m_caps, m_shl, m_shr, m_ctrl, m_alt;
    logic [8:0]  m_held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_err = 0; m_caps = 0; m_shl = 0; m_shr = 0; m_ctrl = 0; m_alt = 0; m_held = '0;
    endtask

    task automatic model_key(input bit ext, input logic [7:0] code, input bit brk);
        logic [8:0]  k;
        bit          sup;
        logic [15:0] ev;
        k   = {ext, code};
        sup = SUPPRESS && !brk && (m_held == k);
        if (code == 8'h12) m_shl  = !brk;
        if (code == 8'h59) m_shr  = !brk;
        if (code == 8'h14) m_ctrl = !brk;
        if (code == 8'h11) m_alt  = !brk;
        if (!brk && !sup && code == 8'h58) m_caps = !m_caps;
        if (!brk) m_held = k;
        else if (m_held == k) m_held = '0;
        if (!sup) begin
            ev = 16'(code) | (16'(brk) << 15) | (16'(ext) << 14) | (16'(m_shl | m_shr) << 13) |
                 (16'(m_ctrl) << 12) | (16'(m_caps) << 11) | (16'(m_alt) << 10);
            if (exp_q.size() < DEPTH) exp_q.push_back(ev);
            else m_err = 1;
        end
    endtask

    // One byte through the handshake: accepted at the next posedge, strobe low one cycle.
    task automatic send_byte(input logic [7:0] b, input bit pop);
        @(negedge clk);
        chk("strobe_idle", kb_nextdata_n, 1'b1);
        if (pop) chk("pop_head", bus.evt_data, exp_q.size() != 0 ? exp_q[0] : 16'h0);
        bus.evt_rd = pop;
        kb_ready   = 1'b1;
        kb_data    = b;
        @(negedge clk);
        bus.evt_rd = 1'b0;
        kb_ready   = 1'b0;
        chk("strobe_low", kb_nextdata_n, 1'b0);
    endtask

    task automatic send_key(input bit ext, input logic [7:0] code, input bit brk,
                            input bit pop_too = 1'b0);
        if (ext) send_byte(8'hE0, 1'b0);
        if (brk) send_byte(8'hF0, 1'b0);
        send_byte(code, pop_too);
        if (pop_too && exp_q.size() != 0) void'(exp_q.pop_front());
        model_key(ext, code, brk);
        // Sampled one cycle after the accepting edge.
        chk("count", bus.evt_count, exp_q.size());
        chk("valid", bus.evt_valid, exp_q.size() != 0);
        chk("caps", caps_led, m_caps);
        chk("err", bus.err, m_err);
    endtask

    task automatic do_pop(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, bus.evt_valid, exp_q.size() != 0);
        chk({tag, "_count"}, bus.evt_count, exp_q.size());
        chk({tag, "_data"}, bus.evt_data, exp_q.size() != 0 ? exp_q[0] : 16'h0);
        bus.evt_rd = 1'b1;
        @(negedge clk);
        bus.evt_rd = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (exp_q.size() != 0) do_pop(tag);
        end
        @(negedge clk);
        chk({tag, "_empty"}, bus.evt_valid, 1'b0);
    endtask

    task automatic pulse_overflow(input bit with_clr);
        @(negedge clk);
        kb_overflow = 1'b1;
        bus.err_clr = with_clr;
        @(negedge clk);
        kb_overflow = 1'b0;
        bus.err_clr = 1'b0;
        m_err = 1;
    endtask

    logic [7:0] codes [12] = '{8'h1C, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58,
                               8'h75, 8'h21, 8'h6B, 8'h74, 8'h1A, 8'h4D};
    logic [7:0] fill  [9]  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] pause [8]  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        bus.evt_rd  = 1'b0;
        bus.err_clr = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_strobe", kb_nextdata_n, 1'b1);
        chk("rst_valid", bus.evt_valid, 1'b0);
        chk("rst_data", bus.evt_data, 16'h0);
        chk("rst_count", bus.evt_count, 0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_caps", caps_led, 1'b0);
        clrn = 1'b1;

        // Plain make / break
        send_key(0, 8'h1C, 0);
        chk("lit_001C", bus.evt_data, 16'h001C);
        send_key(0, 8'h1C, 1);
        do_pop("mb");
        chk("lit_801C", bus.evt_data, 16'h801C);
        drain("mb");

        // Shift tracking
        send_key(0, 8'h12, 0);
        chk("lit_2012", bus.evt_data, 16'h2012);
        send_key(0, 8'h1C, 0);
        send_key(0, 8'h1C, 1);
        send_key(0, 8'h12, 1);
        drain("shift");

        // Extended keys
        send_key(1, 8'h75, 0);
        chk("lit_4075", bus.evt_data, 16'h4075);
        send_key(1, 8'h75, 1);
        drain("ext");

        // Pause sequence swallowed, decoder back in idle, filler dropped
        foreach (pause[i]) send_byte(pause[i], 1'b0);
        send_byte(8'hAA, 1'b0);
        send_key(0, 8'h1C, 0);
        chk("pause_count", bus.evt_count, 1);
        chk("lit_pause_001C", bus.evt_data, 16'h001C);
        send_key(0, 8'h1C, 1);
        drain("pause");

        // Caps lock toggling
        send_key(0, 8'h58, 0);
        chk("caps_on", caps_led, 1'b1);
        send_key(0, 8'h58, 1);
        send_key(0, 8'h58, 0);
        chk("caps_off", caps_led, 1'b0);
        send_key(0, 8'h58, 1);
        drain("caps");

        // Typematic repeat suppression
        repeat (3) send_key(0, 8'h1C, 0);
        send_key(0, 8'h1C, 1);
        chk("rep_count", bus.evt_count, 2);
        drain("rep");
        do_pop("empty_pop");

        // FIFO full: drop sets err, head unchanged, pop+push keeps count
        foreach (fill[i]) send_key(0, fill[i], 0);
        chk("full_count", bus.evt_count, 8);
        chk("full_err", bus.err, 1'b1);
        chk("full_head", bus.evt_data, 16'h0015);
        send_key(0, 8'h4D, 0, 1'b1);
        chk("pp_count", bus.evt_count, 8);
        drain("full");

        // err_clr, and overflow winning over a same-cycle clear
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_err = 0;
        chk("err_clr", bus.err, 1'b0);
        pulse_overflow(1'b1);
        chk("ovf_err", bus.err, 1'b1);

        // Overflow drops a partial E0 sequence
        send_byte(8'hE0, 1'b0);
        pulse_overflow(1'b0);
        send_key(0, 8'h75, 0);
        chk("lit_ovf_0075", bus.evt_data, 16'h0075);
        send_key(0, 8'h75, 1);
        drain("ovf");

        // Reset mid E0 sequence
        send_byte(8'hE0, 1'b0);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
        chk("mid_rst_err", bus.err, 1'b0);
        send_key(0, 8'h75, 0);
        chk("lit_rst_0075", bus.evt_data, 16'h0075);
        drain("rst");

        // Randomised keys against the model
        for (int i = 0; i < 80; i++) begin
            automatic bit         ext = ($urandom_range(0, 3) == 0);
            automatic bit         brk = $urandom_range(0, 1);
            automatic logic [7:0] c   = codes[$urandom_range(0, 11)];
            automatic bit         pp  = (exp_q.size() != 0) && ($urandom_range(0, 3) == 0);
            send_key(ext, c, brk, pp);
            if (exp_q.size() >= 6) do_pop("rnd");
        end
        drain("rnd");
        chk("rnd_err", bus.err, m_err);
        chk("rnd_caps", caps_led, m_caps);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
